// File: rtl/mode7_coord_gen.sv
// Mode 7 texture coordinate generator: scans the raster, feeds dx/dy to external
// sign-magnitude multipliers and sums their products into u/v behind a valid/ready port.
module mode7_coord_gen #(
    parameter int SIZE     = 24,
    parameter int INT_SIZE = 16,
    parameter int DEC_SIZE = 8,
    parameter int SCREEN_W = 256,
    parameter int SCREEN_H = 224
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] par_a,
    input  logic [SIZE-1:0] par_b,
    input  logic [SIZE-1:0] par_c,
    input  logic [SIZE-1:0] par_d,
    input  logic [SIZE-1:0] par_x0,
    input  logic [SIZE-1:0] par_y0,
    output logic [SIZE-1:0] coef_a,
    output logic [SIZE-1:0] coef_b,
    output logic [SIZE-1:0] coef_c,
    output logic [SIZE-1:0] coef_d,
    output logic [SIZE-1:0] op_dx,
    output logic [SIZE-1:0] op_dy,
    input  logic [SIZE-1:0] prod_adx,
    input  logic [SIZE-1:0] prod_bdy,
    input  logic [SIZE-1:0] prod_cdx,
    input  logic [SIZE-1:0] prod_ddy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_u,
    output logic [SIZE-1:0] out_v,
    output logic [8:0]      out_x,
    output logic [7:0]      out_y,
    output logic            out_last,
    output logic            busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam int MW = SIZE - 1;

    typedef struct packed {
        logic       vld;
        logic [8:0] x;
        logic [7:0] y;
        logic       last;
    } pix_t;

    // Sign-magnitude add; -0 is folded to +0 and same-sign overflow saturates.
    function automatic logic [SIZE-1:0] sm_add(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic [MW-1:0] ma, mb, mr;
        logic [MW:0]   sum;
        logic          sa, sb, sr;
        ma  = a[MW-1:0];
        mb  = b[MW-1:0];
        sa  = a[MW] & (|ma);
        sb  = b[MW] & (|mb);
        sum = {1'b0, ma} + {1'b0, mb};
        if (sa == sb) begin
            mr = sum[MW] ? '1 : sum[MW-1:0];
            sr = sa;
        end else if (ma >= mb) begin
            mr = ma - mb;
            sr = sa;
        end else begin
            mr = mb - ma;
            sr = sb;
        end
        if (mr == '0) sr = 1'b0;
        return {sr, mr};
    endfunction

    function automatic logic [SIZE-1:0] sm_neg(input logic [SIZE-1:0] a);
        return {~a[MW], a[MW-1:0]};
    endfunction

    logic [1:0]      state_q, state_d;
    logic [SIZE-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, x0_q, x0_d, y0_q, y0_d;
    logic [8:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    pix_t            s1_q, s1_d, s2_q, s2_d;
    logic [SIZE-1:0] dx_q, dx_d, dy_q, dy_d, u_q, u_d, v_q, v_d;
    logic [SIZE-1:0] x_fix, y_fix;
    logic            adv, pix_last;

    assign x_fix    = {1'b0, (INT_SIZE-1)'(x_q), {DEC_SIZE{1'b0}}};
    assign y_fix    = {1'b0, (INT_SIZE-1)'(y_q), {DEC_SIZE{1'b0}}};
    assign adv      = !s2_q.vld || out_ready;
    assign pix_last = (x_q == 9'(SCREEN_W-1)) && (y_q == 8'(SCREEN_H-1));

    always_comb begin
        state_d = state_q;
        a_d = a_q;  b_d = b_q;  c_d = c_q;  d_d = d_q;  x0_d = x0_q;  y0_d = y0_q;
        x_d = x_q;  y_d = y_q;
        s1_d = s1_q;  dx_d = dx_q;  dy_d = dy_q;
        s2_d = s2_q;  u_d = u_q;  v_d = v_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                a_d = par_a;  b_d = par_b;  c_d = par_c;  d_d = par_d;
                x0_d = par_x0;  y0_d = par_y0;
                x_d = '0;  y_d = '0;
            end
            S_RUN: if (adv) begin
                s1_d = '{vld: 1'b1, x: x_q, y: y_q, last: pix_last};
                dx_d = sm_add(x_fix, sm_neg(x0_q));
                dy_d = sm_add(y_fix, sm_neg(y0_q));
                if (pix_last) begin
                    state_d = S_DRAIN;
                end else if (x_q == 9'(SCREEN_W-1)) begin
                    x_d = '0;
                    y_d = y_q + 8'd1;
                end else begin
                    x_d = x_q + 9'd1;
                end
            end
            S_DRAIN: begin
                if (adv) s1_d.vld = 1'b0;
                if (s2_q.vld && s2_q.last && out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Products are combinational from the stage1 operands, so stage2 sees them this cycle.
        if (adv) begin
            s2_d.vld = s1_q.vld;
            if (s1_q.vld) begin
                s2_d = s1_q;
                u_d  = sm_add(sm_add(prod_adx, prod_bdy), x0_q);
                v_d  = sm_add(sm_add(prod_cdx, prod_ddy), y0_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q <= '0;  b_q <= '0;  c_q <= '0;  d_q <= '0;  x0_q <= '0;  y0_q <= '0;
            x_q <= '0;  y_q <= '0;
            s1_q <= '0;  dx_q <= '0;  dy_q <= '0;
            s2_q <= '0;  u_q <= '0;  v_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;  b_q <= b_d;  c_q <= c_d;  d_q <= d_d;  x0_q <= x0_d;  y0_q <= y0_d;
            x_q <= x_d;  y_q <= y_d;
            s1_q <= s1_d;  dx_q <= dx_d;  dy_q <= dy_d;
            s2_q <= s2_d;  u_q <= u_d;  v_q <= v_d;
        end
    end

    assign coef_a    = a_q;
    assign coef_b    = b_q;
    assign coef_c    = c_q;
    assign coef_d    = d_q;
    assign op_dx     = dx_q;
    assign op_dy     = dy_q;
    assign out_valid = s2_q.vld;
    assign out_u     = u_q;
    assign out_v     = v_q;
    assign out_x     = s2_q.x;
    assign out_y     = s2_q.y;
    assign out_last  = s2_q.vld & s2_q.last;
    assign busy      = (state_q != S_IDLE);
endmodule
